// File: rtl/dds_enable_gen.sv
// dds_enable_gen: runtime-programmable phase-accumulator rate-enable generator.
// Emits cfg_add enables per cfg_max cycles, with start/stop, finite bursts and shadowed reconfiguration.
module dds_enable_gen #(
  parameter int WIDTH   = 16,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   cfg_add,
  input  logic [WIDTH-1:0]   cfg_max,
  input  logic               cfg_load,
  input  logic               start,
  input  logic               stop,
  input  logic [BURST_W-1:0] burst_len,
  output logic               enable,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]         state_q, state_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   add_q, add_d, max_q, max_d, sadd_q, sadd_d, smax_q, smax_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               pend_q, pend_d, done_q, done_d, err_q, err_d;
  logic               ld_ok, run, en, last, go, apply;
  assign ld_ok = cfg_load && cfg_max != '0 && cfg_add != '0 && cfg_add <= cfg_max;
  assign run   = state_q == RUN;
  assign en    = run && acc_q >= {1'b0, max_q};
  assign last  = en && rem_q == BURST_W'(1);
  // active config is either all-zero or valid, so a nonzero add means it can be started
  assign go    = !run && start && !stop && (ld_ok || add_q != '0);
  assign apply = en && pend_q;
  always_comb begin
    state_d = run ? ((stop || last) ? IDLE : RUN) : (go ? RUN : IDLE);
    acc_d   = (!run || apply) ? '0
            : en ? acc_q + {1'b0, add_q} - {1'b0, max_q} : acc_q + {1'b0, add_q};
    add_d   = (!run && ld_ok) ? cfg_add : apply ? sadd_q : add_q;
    max_d   = (!run && ld_ok) ? cfg_max : apply ? smax_q : max_q;
    sadd_d  = (run && ld_ok) ? cfg_add : sadd_q;
    smax_d  = (run && ld_ok) ? cfg_max : smax_q;
    pend_d  = state_d == RUN && ((run && ld_ok) || (pend_q && !en));
    rem_d   = go ? burst_len : (en && rem_q != '0) ? rem_q - BURST_W'(1) : rem_q;
    done_d  = last && !stop;
    err_d   = (cfg_load && !ld_ok) || (!run && start && !stop && !go);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      add_q   <= '0;
      max_q   <= '0;
      sadd_q  <= '0;
      smax_q  <= '0;
      pend_q  <= 1'b0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      add_q   <= add_d;
      max_q   <= max_d;
      sadd_q  <= sadd_d;
      smax_q  <= smax_d;
      pend_q  <= pend_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign enable  = en;
  assign busy    = run;
  assign done    = done_q;
  assign cfg_err = err_q;
endmodule
